// File: rtl/bus_arb_pkg.sv
// Shared definitions for the datapath bus arbiter: state encoding, default sizing and
// a one-hot decode helper that the datapath checker also uses.
package bus_arb_pkg;

  localparam int N_REQ_DEF    = 20;
  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic int onehot_to_index(input logic [63:0] oh);
    int idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching ptr, ptr+1, ... with explicit
// wrap at N_REQ, so the request count need not be a power of two.
module rr_pick #(
  parameter int N_REQ = 20,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             found,
  output logic [IDW-1:0]   winner
);

  always_comb begin : search
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Tri-state bus arbiter: round-robin grant with optional bounded lock and a dead
// turnaround cycle between different owners. All grant outputs are registered.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int MAX_HOLD   = MAX_HOLD_DEF,
  parameter int TURNAROUND = 1,
  localparam int IDW       = $clog2(N_REQ),
  localparam int HCW       = $clog2(MAX_HOLD) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  output logic [N_REQ-1:0] gnt_OH,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id,
  output arb_state_t       dbg_state
);

  arb_state_t       state_q, state_n;
  logic [IDW-1:0]   owner_q, owner_n;
  logic [IDW-1:0]   ptr_q, ptr_n;
  logic [HCW-1:0]   hold_q, hold_n;
  logic [IDW-1:0]   owner_inc;
  logic [IDW-1:0]   pick_ptr;
  logic             keep;
  logic             found;
  logic [IDW-1:0]   winner;
  logic [N_REQ-1:0] gnt_oh_n;
  logic [IDW-1:0]   gnt_id_n;

  assign owner_inc = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + IDW'(1);
  assign keep      = req[owner_q] & lock[owner_q] & (hold_q < HCW'(MAX_HOLD - 1));
  // A releasing owner re-arbitrates from the slot after itself.
  assign pick_ptr  = (state_q == GRANT) ? owner_inc : ptr_q;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .found  (found),
    .winner (winner)
  );

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          owner_n = winner;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (keep) begin
          hold_n = hold_q + HCW'(1);
        end else begin
          ptr_n = owner_inc;
          if (!found) begin
            state_n = IDLE;
          end else if (winner == owner_q) begin
            hold_n = '0;
          end else if (TURNAROUND != 0) begin
            state_n = TURN;
          end else begin
            owner_n = winner;
            hold_n  = '0;
          end
        end
      end
      TURN: begin
        if (found) begin
          state_n = GRANT;
          owner_n = winner;
          hold_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_oh_n = '0;
    gnt_id_n = '0;
    if (state_n == GRANT) begin
      gnt_oh_n[owner_n] = 1'b1;
      gnt_id_n          = owner_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_OH    <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state_q   <= state_n;
      owner_q   <= owner_n;
      ptr_q     <= ptr_n;
      hold_q    <= hold_n;
      gnt_OH    <= gnt_oh_n;
      gnt_valid <= |gnt_oh_n;
      gnt_id    <= gnt_id_n;
    end
  end

  assign dbg_state = state_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_OH));
  a_valid:  assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt_OH));
  a_id:     assert property (@(posedge clk) disable iff (rst)
                             gnt_id == (gnt_valid ? IDW'(onehot_to_index(64'(gnt_OH))) : '0));

  generate
    if (TURNAROUND != 0) begin : g_turn_chk
      // No direct handover between two different nonzero enables.
      a_no_overlap: assert property (@(posedge clk) disable iff (rst)
                                     (gnt_valid && $past(gnt_valid)) |-> gnt_OH == $past(gnt_OH));
    end
  endgenerate

endmodule
